// File: rtl/cpu_pkg.sv
// Shared types for the microcoded accumulator CPU: instruction layout, ALU
// opcodes, source/target selectors and the run/halt state.
package cpu_pkg;

    localparam int INSTR_W    = 48;
    localparam int IMM8_LSB   = 0;
    localparam int JMP_HI_LSB = 8;
    localparam int TARGET_LSB = 16;
    localparam int RSVD_LSB   = 31;

    typedef enum logic [4:0] {
        ALU_ZERO      = 5'd0,
        ALU_A         = 5'd1,
        ALU_B         = 5'd2,
        ALU_A_PLUS_B  = 5'd3,
        ALU_A_MINUS_B = 5'd4,
        ALU_A_PLUS_1  = 5'd5,
        ALU_B_PLUS_1  = 5'd6,
        ALU_A_MINUS_1 = 5'd7,
        ALU_AND       = 5'd8,
        ALU_OR        = 5'd9,
        ALU_XOR       = 5'd10,
        ALU_NOT_A     = 5'd11
    } alu_op_t;

    typedef enum logic [2:0] {
        TGT_REG0  = 3'd0,
        TGT_REG1  = 3'd1,
        TGT_REG2  = 3'd2,
        TGT_REG3  = 3'd3,
        TGT_MARLO = 3'd4,
        TGT_MARHI = 3'd5,
        TGT_JMP   = 3'd6,
        TGT_HALT  = 3'd7
    } target_t;

    typedef enum logic [2:0] {
        SRC_REG0  = 3'd0,
        SRC_REG1  = 3'd1,
        SRC_REG2  = 3'd2,
        SRC_REG3  = 3'd3,
        SRC_MARLO = 3'd4,
        SRC_MARHI = 3'd5,
        SRC_ZERO6 = 3'd6,
        SRC_ZERO7 = 3'd7
    } src_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } run_state_t;

    typedef struct packed {
        logic [INSTR_W-1:RSVD_LSB]       reserved;
        logic                            b_imm;
        alu_op_t                         alu_op;
        src_t                            b_src;
        src_t                            a_src;
        target_t                         target;
        logic [TARGET_LSB-1:JMP_HI_LSB]  jmp_hi;
        logic [JMP_HI_LSB-1:IMM8_LSB]    imm8;
    } instr_t;

    // Only the arithmetic ops write the carry flag.
    function automatic logic op_sets_carry(alu_op_t op);
        return op inside {ALU_A_PLUS_B, ALU_A_MINUS_B, ALU_A_PLUS_1,
                          ALU_B_PLUS_1, ALU_A_MINUS_1};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 8-bit ALU; carry_out is bit 8 of the 9-bit result, which is
// the borrow for the subtracting ops.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [4:0] op,
    input  logic       carry_in,
    output logic [7:0] result,
    output logic       carry_out
);

    logic [8:0] sum9;

    always_comb begin
        sum9 = '0;
        case (alu_op_t'(op))
            ALU_ZERO:      sum9 = 9'd0;
            ALU_A:         sum9 = {1'b0, a};
            ALU_B:         sum9 = {1'b0, b};
            ALU_A_PLUS_B:  sum9 = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
            ALU_A_MINUS_B: sum9 = {1'b0, a} - {1'b0, b};
            ALU_A_PLUS_1:  sum9 = {1'b0, a} + 9'd1;
            ALU_B_PLUS_1:  sum9 = {1'b0, b} + 9'd1;
            ALU_A_MINUS_1: sum9 = {1'b0, a} - 9'd1;
            ALU_AND:       sum9 = {1'b0, a & b};
            ALU_OR:        sum9 = {1'b0, a | b};
            ALU_XOR:       sum9 = {1'b0, a ^ b};
            ALU_NOT_A:     sum9 = {1'b0, ~a};
            default:       sum9 = 9'd0;
        endcase
    end

    assign result    = sum9[7:0];
    assign carry_out = sum9[8];

endmodule

// File: rtl/cpu_core.sv
// 8-bit microcoded CPU: one 48-bit instruction per clock from a loadable
// program store read combinationally at the current PC.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int ROM_DEPTH = 256,
    parameter int ROM_WIDTH = 48
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rom_we,
    input  logic [7:0]           rom_waddr,
    input  logic [ROM_WIDTH-1:0] rom_wdata,
    output logic [15:0]          pc,
    output logic [7:0]           reg_a,
    output logic [7:0]           reg_b,
    output logic [7:0]           marlo,
    output logic [7:0]           marhi,
    output logic [7:0]           alu_result,
    output logic                 carry,
    output logic                 halted
);

    localparam int ADDR_W = $clog2(ROM_DEPTH);

    logic [ROM_WIDTH-1:0] rom_mem [ROM_DEPTH];

    logic [15:0]      pc_reg, pc_next;
    logic [7:0]       marlo_reg, marlo_next;
    logic [7:0]       marhi_reg, marhi_next;
    logic             carry_reg, carry_next;
    run_state_t       state_reg, state_next;
    logic [3:0]       reg_we;
    logic [3:0][7:0]  reg_file;

    instr_t     instr;
    logic [7:0] a_bus, b_bus, alu_res;
    logic       alu_carry;
    logic       unused_rsvd;

    // Program loads are independent of reset so the bench can load while
    // the core is held in reset.
    always_ff @(posedge clk) begin
        if (rom_we) begin
            rom_mem[rom_waddr[ADDR_W-1:0]] <= rom_wdata;
        end
    end

    assign instr       = instr_t'(rom_mem[pc_reg[ADDR_W-1:0]]);
    assign unused_rsvd = ^instr.reserved;

    function automatic logic [7:0] select_src(
        input src_t       sel,
        input logic [3:0][7:0] regs,
        input logic [7:0] lo,
        input logic [7:0] hi
    );
        case (sel)
            SRC_REG0:  return regs[0];
            SRC_REG1:  return regs[1];
            SRC_REG2:  return regs[2];
            SRC_REG3:  return regs[3];
            SRC_MARLO: return lo;
            SRC_MARHI: return hi;
            default:   return 8'h00;
        endcase
    endfunction

    assign a_bus = select_src(instr.a_src, reg_file, marlo_reg, marhi_reg);
    assign b_bus = instr.b_imm ? instr.imm8
                               : select_src(instr.b_src, reg_file, marlo_reg, marhi_reg);

    cpu_alu u_alu (
        .a         (a_bus),
        .b         (b_bus),
        .op        (instr.alu_op),
        .carry_in  (carry_reg),
        .result    (alu_res),
        .carry_out (alu_carry)
    );

    // Execute: a HALT does not retire, so PC stays on the HALT word.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        reg_we     = '0;
        marlo_next = marlo_reg;
        marhi_next = marhi_reg;
        carry_next = carry_reg;
        if (state_reg == ST_RUN) begin
            case (instr.target)
                TGT_JMP:  pc_next = {instr.jmp_hi, instr.imm8};
                TGT_HALT: state_next = ST_HALT;
                default: begin
                    pc_next = pc_reg + 16'd1;
                    if (op_sets_carry(instr.alu_op)) begin
                        carry_next = alu_carry;
                    end
                    case (instr.target)
                        TGT_MARLO: marlo_next = alu_res;
                        TGT_MARHI: marhi_next = alu_res;
                        default:   reg_we[instr.target[1:0]] = 1'b1;
                    endcase
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_regfile
        logic [7:0] r_reg;
        always_ff @(posedge clk) begin
            if (reset) begin
                r_reg <= '0;
            end else if (reg_we[gi]) begin
                r_reg <= alu_res;
            end
        end
        assign reg_file[gi] = r_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg    <= '0;
            marlo_reg <= '0;
            marhi_reg <= '0;
            carry_reg <= 1'b0;
            state_reg <= ST_RUN;
        end else begin
            pc_reg    <= pc_next;
            marlo_reg <= marlo_next;
            marhi_reg <= marhi_next;
            carry_reg <= carry_next;
            state_reg <= state_next;
        end
    end

    assign pc         = pc_reg;
    assign reg_a      = reg_file[0];
    assign reg_b      = reg_file[1];
    assign marlo      = marlo_reg;
    assign marhi      = marhi_reg;
    assign alu_result = alu_res;
    assign carry      = carry_reg;
    assign halted     = (state_reg == ST_HALT);

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: an instruction-level interpreter tracks architectural
// state every clock; directed programs add explicit end-to-end checks.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        rom_we;
    logic [7:0]  rom_waddr;
    logic [47:0] rom_wdata;
    logic [15:0] pc;
    logic [7:0]  reg_a, reg_b, marlo, marhi, alu_result;
    logic        carry, halted;

    cpu_core #(.ROM_DEPTH(256), .ROM_WIDTH(48)) dut (
        .clk        (clk),
        .reset      (reset),
        .rom_we     (rom_we),
        .rom_waddr  (rom_waddr),
        .rom_wdata  (rom_wdata),
        .pc         (pc),
        .reg_a      (reg_a),
        .reg_b      (reg_b),
        .marlo      (marlo),
        .marhi      (marhi),
        .alu_result (alu_result),
        .carry      (carry),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 1'b0;

    logic [47:0] prog  [256];
    logic [47:0] m_rom [256];
    int m_pc, m_marlo, m_marhi, m_carry, m_halted;
    int m_reg [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] mk(input int tgt, input int op, input int asrc,
                                       input int bsrc, input int bimm, input int imm,
                                       input int jhi);
        logic [47:0] w;
        w        = '0;
        w[7:0]   = imm[7:0];
        w[15:8]  = jhi[7:0];
        w[18:16] = tgt[2:0];
        w[21:19] = asrc[2:0];
        w[24:22] = bsrc[2:0];
        w[29:25] = op[4:0];
        w[30]    = bimm[0];
        return w;
    endfunction

    function automatic int src_val(input int s);
        if (s < 4)  return m_reg[s];
        if (s == 4) return m_marlo;
        if (s == 5) return m_marhi;
        return 0;
    endfunction

    function automatic void model_alu(input logic [47:0] w, output int res, output int cout);
        int a, b, s;
        a = src_val(int'(w[21:19]));
        b = w[30] ? int'(w[7:0]) : src_val(int'(w[24:22]));
        s = 0;
        cout = 0;
        case (int'(w[29:25]))
            0:  s = 0;
            1:  s = a;
            2:  s = b;
            3:  begin s = a + b + m_carry; cout = (s > 255) ? 1 : 0; end
            4:  begin s = a - b;           cout = (a < b) ? 1 : 0; end
            5:  begin s = a + 1;           cout = (s > 255) ? 1 : 0; end
            6:  begin s = b + 1;           cout = (s > 255) ? 1 : 0; end
            7:  begin s = a - 1;           cout = (a == 0) ? 1 : 0; end
            8:  s = a & b;
            9:  s = a | b;
            10: s = a ^ b;
            11: s = 255 - a;
            default: s = 0;
        endcase
        res = s & 255;
    endfunction

    task automatic model_edge(input bit rst, input bit we, input logic [7:0] wa,
                              input logic [47:0] wd);
        logic [47:0] w;
        int res, cout, tgt, op;
        w = m_rom[m_pc & 255];
        if (rst) begin
            m_pc = 0; m_marlo = 0; m_marhi = 0; m_carry = 0; m_halted = 0;
            for (int i = 0; i < 4; i++) m_reg[i] = 0;
        end else if (m_halted == 0) begin
            model_alu(w, res, cout);
            tgt = int'(w[18:16]);
            op  = int'(w[29:25]);
            if (tgt == 6) begin
                m_pc = int'({w[15:8], w[7:0]});
            end else if (tgt == 7) begin
                m_halted = 1;
            end else begin
                if (tgt < 4)       m_reg[tgt] = res;
                else if (tgt == 4) m_marlo = res;
                else               m_marhi = res;
                if (op >= 3 && op <= 7) m_carry = cout;
                m_pc = (m_pc + 1) % 65536;
            end
        end
        if (we) m_rom[wa] = wd;
    endtask

    task automatic compare_all();
        int res, cout;
        model_alu(m_rom[m_pc & 255], res, cout);
        check("pc",         32'(pc),         m_pc);
        check("reg_a",      32'(reg_a),      m_reg[0]);
        check("reg_b",      32'(reg_b),      m_reg[1]);
        check("marlo",      32'(marlo),      m_marlo);
        check("marhi",      32'(marhi),      m_marhi);
        check("carry",      32'(carry),      m_carry);
        check("halted",     32'(halted),     m_halted);
        check("alu_result", 32'(alu_result), res);
    endtask

    task automatic cycle();
        bit r, we;
        logic [7:0] wa;
        logic [47:0] wd;
        r = reset; we = rom_we; wa = rom_waddr; wd = rom_wdata;
        @(posedge clk);
        model_edge(r, we, wa, wd);
        #1;
        if (checking) compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    // Loads prog[] with reset held, then leaves reset deasserted.
    task automatic load_prog();
        checking = 1'b0;
        reset    = 1'b1;
        rom_we   = 1'b1;
        for (int i = 0; i < 256; i++) begin
            rom_waddr = 8'(i);
            rom_wdata = prog[i];
            cycle();
        end
        rom_we   = 1'b0;
        checking = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) prog[i] = mk(7, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic random_prog();
        int r, tgt, jhi;
        for (int i = 0; i < 256; i++) begin
            r = $urandom_range(0, 99);
            jhi = 0;
            if (r < 2)       tgt = 7;
            else if (r < 10) begin
                tgt = 6;
                if ($urandom_range(0, 3) == 0) jhi = $urandom_range(0, 255);
            end else         tgt = $urandom_range(0, 5);
            prog[i] = mk(tgt, $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 1), $urandom_range(0, 255), jhi);
            prog[i][47:31] = 17'($urandom);
        end
    endtask

    task automatic counter_test(input int start, input int iters);
        int count;
        fill_halt();
        prog[0] = mk(0, 2, 0, 0, 1, start & 255, 0);
        prog[1] = mk(1, 2, 0, 0, 1, (start >> 8) & 255, 0);
        prog[2] = mk(4, 2, 0, 0, 1, 0, 0);
        prog[3] = mk(0, 5, 0, 0, 0, 0, 0);
        prog[4] = mk(1, 3, 1, 0, 1, 0, 0);
        prog[5] = mk(4, 6, 0, 0, 0, 0, 0);
        prog[6] = mk(6, 0, 0, 0, 0, 3, 0);
        load_prog();
        run(3);
        check("cnt_init", 32'({reg_b, reg_a}), start);
        count = start;
        for (int k = 0; k < iters; k++) begin
            cycle();
            check("cnt_inc_carry", 32'(carry), ((count & 255) == 255) ? 1 : 0);
            run(3);
            count = (count + 1) % 65536;
            check("cnt_value", 32'({reg_b, reg_a}), count);
            check("cnt_marlo", 32'(marlo), ((count & 255) + 1) & 255);
            check("cnt_pc",    32'(pc), 3);
        end
        $display("counter program from 0x%04h: %0d iterations, count now 0x%04h", start, iters, count);
    endtask

    initial begin
        reset     = 1'b1;
        rom_we    = 1'b0;
        rom_waddr = '0;
        rom_wdata = '0;
        for (int i = 0; i < 256; i++) m_rom[i] = '0;
        for (int i = 0; i < 4; i++) m_reg[i] = 0;
        m_pc = 0; m_marlo = 0; m_marhi = 0; m_carry = 0; m_halted = 0;

        // Random program to dirty the state, then a 3-cycle reset.
        random_prog();
        load_prog();
        run(60);
        reset = 1'b1;
        run(3);
        check("rst_pc",     32'(pc), 0);
        check("rst_reg_a",  32'(reg_a), 0);
        check("rst_reg_b",  32'(reg_b), 0);
        check("rst_marlo",  32'(marlo), 0);
        check("rst_carry",  32'(carry), 0);
        check("rst_halted", 32'(halted), 0);
        reset = 1'b0;
        $display("reset after random program: pc=0x%04h halted=%0d", pc, halted);

        // Immediate load then HALT.
        fill_halt();
        prog[0] = mk(0, 2, 0, 0, 1, 'h5A, 0);
        load_prog();
        cycle();
        check("imm_reg_a", 32'(reg_a), 'h5A);
        check("imm_pc",    32'(pc), 1);
        run(4);
        check("halt_pc",     32'(pc), 1);
        check("halt_flag",   32'(halted), 1);
        check("halt_reg_a",  32'(reg_a), 'h5A);
        $display("immediate load + halt: reg_a=0x%02h pc=0x%04h halted=%0d", reg_a, pc, halted);

        counter_test(0, 6);
        counter_test('h00FF, 3);
        counter_test('hFFFF, 3);

        // Subtract with borrow, jumps, and 16-bit PC wrap.
        fill_halt();
        prog[0]    = mk(0, 2, 0, 0, 1, 'h00, 0);
        prog[1]    = mk(1, 2, 0, 0, 1, 'h01, 0);
        prog[2]    = mk(2, 4, 0, 1, 0, 0, 0);
        prog[3]    = mk(0, 1, 2, 0, 0, 0, 0);
        prog[4]    = mk(6, 0, 0, 0, 0, 'h34, 'h12);
        prog['h34] = mk(6, 0, 0, 0, 0, 'hFF, 'hFF);
        prog['hFF] = mk(3, 0, 0, 0, 0, 0, 0);
        load_prog();
        run(3);
        check("sub_borrow", 32'(carry), 1);
        cycle();
        check("sub_result", 32'(reg_a), 'hFF);
        cycle();
        check("jmp_pc",    32'(pc), 'h1234);
        check("jmp_carry", 32'(carry), 1);
        cycle();
        check("jmp_pc_ffff", 32'(pc), 'hFFFF);
        cycle();
        check("pc_wrap",       32'(pc), 0);
        check("pc_wrap_carry", 32'(carry), 1);
        $display("subtract/jump/wrap program: pc=0x%04h carry=%0d", pc, carry);

        // Random programs with random mid-run resets.
        for (int p = 0; p < 3; p++) begin
            random_prog();
            load_prog();
            for (int c = 0; c < 300; c++) begin
                reset = ($urandom_range(0, 99) < 4);
                cycle();
            end
            reset = 1'b0;
            $display("random program %0d: 300 cycles, pc=0x%04h halted=%0d", p, pc, halted);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- 8-bit accumulator/register CPU executing 48-bit microcoded instructions from an internal, loadable program ROM.
- One instruction per clock.
- Contains a PC, a 4-entry register file, a memory address register (MARHI/MARLO), an ALU with a carry flag, and unconditional jumps.
- It is the top compute block; the bench loads the program, releases reset, and observes architectural state through debug outputs.

Parameters:
- ROM_DEPTH, 256: program words; PC low log2(ROM_DEPTH) bits index ROM.
- ROM_WIDTH, 48: instruction width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- rom_we  in  1  program-load write strobe.
- rom_waddr  in  8  program-load address.
- rom_wdata  in  48  program-load word.
- pc  out  16  current PC {PCHI,PCLO}.
- reg_a, reg_b  out  8 each  register file entries 0 and 1.
- marlo, marhi  out  8 each  MAR halves.
- alu_result  out  8  current combinational ALU result.
- carry  out  1  carry flag.
- halted  out  1  CPU stopped.

Behaviour:
- Reset (sync, active-high) clears PC, regs 0..3, MARLO, MARHI, carry and halted. ROM is not cleared.
- ROM writes occur on clk when rom_we=1, regardless of reset. ROM reads are combinational at pc.
- Instruction fields:
  - [7:0] imm8
  - [15:8] jmp_hi
  - [18:16] target
  - [21:19] a_src
  - [24:22] b_src
  - [29:25] alu_op
  - [30] b_imm: bbus=imm8 instead of b_src
  - [47:31] reserved, ignored
- a_src/b_src encoding: 0-3 = reg0..3, 4 = marlo, 5 = marhi, 6-7 = 0x00.
- ALU ops:
  - 0 ZERO
  - 1 A
  - 2 B
  - 3 A_PLUS_B: A+B+carry_in
  - 4 A_MINUS_B: A-B, carry = borrow
  - 5 A_PLUS_1
  - 6 B_PLUS_1
  - 7 A_MINUS_1
  - 8 AND
  - 9 OR
  - 10 XOR
  - 11 NOT_A
  - others yield 0x00
- Carry updates only on ops 3-7 and only when the instruction retires. It takes bit 8 of the 9-bit sum (borrow for 4 and 7).
- Ops 5 and 6 ignore carry_in. Op 3 consumes and reproduces it (0xFF+0x00+1 → 0x00, carry=1).
- Targets: 0-3 write alu_result to reg0..3; 4 marlo; 5 marhi.
- Target 6 is JMP: pc <= {jmp_hi, imm8}, no register write, carry unchanged.
- Target 7 is HALT: halted=1, and PC and all state freeze until reset.
- Non-jump instructions: pc <= pc+1. 16-bit wrap 0xFFFF → 0x0000.
- Immediate load is op B with b_imm=1.
- Each instruction completes in exactly 1 clock. The first instruction executes on the first edge after reset deasserts.
- Reset asserted mid-program wins over any write on that edge.

Decomposition:
- Package cpu_pkg holds:
  - alu_op_t enum
  - target_t and src_t enums
  - instruction field position constants
  - typedef instr_t (packed struct)
- One sub-module: cpu_alu, combinational, with inputs a, b, op, carry_in and outputs result and carry_out.

Test Plan:
- Reset held 3 cycles with garbage in regs → pc=0, reg_a=reg_b=marlo=0, carry=0, halted=0.
- Load imm8 0x5A into reg0, then HALT → reg_a=0x5A after 1 clock, pc stops at 1, halted=1.
- 16-bit counter program, loop at address 3:
  - Program: reg0=0, reg1=0, marlo=0, reg0=A_PLUS_1(reg0), reg1=A_PLUS_B(reg1, imm 0), marlo=B_PLUS_1(b=reg0), JMP 3.
  - Expected: each 4-cycle iteration increments {reg_b,reg_a} by exactly 1.
  - Expected: marlo = reg_a+1 mod 256.
- Same program at 0x00FF → next count 0x0100: carry propagates into reg_b.
- Same program at 0xFFFF → next count 0x0000: carry=1 then cleared on next A_PLUS_1.
- A_MINUS_B 0x00-0x01 → 0xFF with carry=1; JMP to 0x1234 → pc=0x1234 with carry unchanged.
